// File: rtl/exu_bp_pkg.sv
// Shared types and defaults for the EXU branch-predictor update path.
package exu_bp_pkg;

  localparam int BP_UPD_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:1] pc;
    logic        misp;
    logic        ataken;
    logic [1:0]  hist;
    logic        way;
  } bp_upd_pkt_t;

endpackage

// File: rtl/exu_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module exu_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/exu_bp_upd_queue.sv
// In-order queue of resolved branch updates toward the predictor table-write port,
// with one-cycle-late cancel of the youngest entry and saturating statistics.
module exu_bp_upd_queue
  import exu_bp_pkg::*;
#(
  parameter int DEPTH = BP_UPD_DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [31:1]      enq_pc,
  input  logic             enq_misp,
  input  logic             enq_ataken,
  input  logic [1:0]       enq_hist,
  input  logic             enq_way,
  input  logic             enq_kill,
  input  logic             stat_clr,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [31:1]      upd_pc,
  output logic             upd_misp,
  output logic             upd_ataken,
  output logic [1:0]       upd_hist,
  output logic             upd_way,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt_accept,
  output logic [CNT_W-1:0] cnt_misp,
  output logic [CNT_W-1:0] cnt_drop,
  output logic [CNT_W-1:0] cnt_kill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  bp_upd_pkt_t      mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] we;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W:0]   count;
  logic             last_enq;

  logic        kill;
  logic        kill_head;
  logic        deq;
  logic        acc;
  logic        drop;
  bp_upd_pkt_t enq_pkt;
  bp_upd_pkt_t head_pkt;

  always_comb begin
    enq_pkt.pc     = enq_pc;
    enq_pkt.misp   = enq_misp;
    enq_pkt.ataken = enq_ataken;
    enq_pkt.hist   = enq_hist;
    enq_pkt.way    = enq_way;

    kill      = enq_kill & last_enq;
    // A kill of the only entry hides the head so the predictor cannot take it.
    kill_head = kill & (count == ONE_CNT);
    upd_valid = vld[rd_ptr] & ~kill_head;
    deq       = upd_valid & upd_ready;
    acc       = enq_valid & ((count != FULL_CNT) | deq);
    drop      = enq_valid & ~acc;
    // Kill + enqueue overwrites the killed slot instead of advancing.
    wr_addr   = kill ? (wr_ptr - 1'b1) : wr_ptr;

    we = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      we[i] = acc & (wr_addr == PTR_W'(i));
    end

    vld_nxt = vld;
    if (deq)  vld_nxt[rd_ptr]  = 1'b0;
    if (kill) vld_nxt[wr_addr] = 1'b0;
    if (acc)  vld_nxt[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_enq <= 1'b0;
      vld      <= '0;
    end else begin
      last_enq <= acc;
      vld      <= vld_nxt;
      count    <= count + {{PTR_W{1'b0}}, acc} - {{PTR_W{1'b0}}, deq}
                        - {{PTR_W{1'b0}}, kill};
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (acc && !kill) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (kill && !acc) begin
        wr_ptr <= wr_ptr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (we[i]) mem[i] <= enq_pkt;
      end
    end
  end

  assign head_pkt   = mem[rd_ptr];
  assign upd_pc     = head_pkt.pc;
  assign upd_misp   = head_pkt.misp;
  assign upd_ataken = head_pkt.ataken;
  assign upd_hist   = head_pkt.hist;
  assign upd_way    = head_pkt.way;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);

  exu_sat_cnt #(.CNT_W(CNT_W)) u_cnt_accept (
    .clk(clk), .rst(rst), .inc(acc), .clr(stat_clr), .q(cnt_accept)
  );
  exu_sat_cnt #(.CNT_W(CNT_W)) u_cnt_misp (
    .clk(clk), .rst(rst), .inc(acc & enq_misp), .clr(stat_clr), .q(cnt_misp)
  );
  exu_sat_cnt #(.CNT_W(CNT_W)) u_cnt_drop (
    .clk(clk), .rst(rst), .inc(drop), .clr(stat_clr), .q(cnt_drop)
  );
  exu_sat_cnt #(.CNT_W(CNT_W)) u_cnt_kill (
    .clk(clk), .rst(rst), .inc(kill), .clr(stat_clr), .q(cnt_kill)
  );

endmodule

// File: tb/tb_exu_bp_upd_queue.sv
// Bench for exu_bp_upd_queue: directed vector table, queue-based random model, counter saturation.
module tb_exu_bp_upd_queue;
  import exu_bp_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic        clk, rst;
  logic        enq_valid, enq_misp, enq_ataken, enq_way, enq_kill, stat_clr;
  logic [31:1] enq_pc;
  logic [1:0]  enq_hist;
  logic        upd_valid, upd_ready, upd_misp, upd_ataken, upd_way, full, empty;
  logic [31:1] upd_pc;
  logic [1:0]  upd_hist;
  logic [CNT_W-1:0] cnt_accept, cnt_misp, cnt_drop, cnt_kill;

  exu_bp_upd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_misp(enq_misp),
    .enq_ataken(enq_ataken), .enq_hist(enq_hist), .enq_way(enq_way),
    .enq_kill(enq_kill), .stat_clr(stat_clr),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_misp(upd_misp), .upd_ataken(upd_ataken), .upd_hist(upd_hist),
    .upd_way(upd_way), .full(full), .empty(empty),
    .cnt_accept(cnt_accept), .cnt_misp(cnt_misp),
    .cnt_drop(cnt_drop), .cnt_kill(cnt_kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  typedef struct {
    bit          ev;
    logic [30:0] pc;
    bit          misp;
    bit          kill;
    bit          rdy;
    bit          clr;
    bit          e_valid;
    bit          chk_pc;
    logic [30:0] e_pc;
    bit          e_empty;
    bit          e_full;
    int          e_acc;
    int          e_misp;
    int          e_drop;
    int          e_kill;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a plain queue of packets plus counters.
  bp_upd_pkt_t mq[$];
  bit m_last;
  int m_acc, m_misp, m_drop, m_kill;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic idle_inputs();
    enq_valid = 0; enq_pc = '0; enq_misp = 0; enq_ataken = 0; enq_hist = '0;
    enq_way = 0; enq_kill = 0; stat_clr = 0; upd_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_last = 0; m_acc = 0; m_misp = 0; m_drop = 0; m_kill = 0;
  endtask

  task automatic model_cycle();
    bit kill, uv, deq, acc;
    bp_upd_pkt_t pkt;
    #1;
    kill = enq_kill && m_last;
    uv   = (mq.size() > 0) && !(kill && mq.size() == 1);
    deq  = uv && upd_ready;
    acc  = enq_valid && ((mq.size() < DEPTH) || deq);
    pkt  = '{pc: enq_pc, misp: enq_misp, ataken: enq_ataken, hist: enq_hist, way: enq_way};
    chk("rnd_upd_valid", upd_valid, uv);
    if (uv) chk("rnd_head_pkt", {upd_pc, upd_misp, upd_ataken, upd_hist, upd_way}, mq[0]);
    chk("rnd_full", full, mq.size() == DEPTH);
    chk("rnd_empty", empty, mq.size() == 0);
    chk("rnd_cnt_accept", cnt_accept, m_acc);
    chk("rnd_cnt_misp", cnt_misp, m_misp);
    chk("rnd_cnt_drop", cnt_drop, m_drop);
    chk("rnd_cnt_kill", cnt_kill, m_kill);
    @(posedge clk);
    if (deq)  void'(mq.pop_front());
    if (kill) void'(mq.pop_back());
    if (acc)  mq.push_back(pkt);
    if (stat_clr) begin
      m_acc = 0; m_misp = 0; m_drop = 0; m_kill = 0;
    end else begin
      if (acc)              m_acc  = sat_inc(m_acc);
      if (acc && enq_misp)  m_misp = sat_inc(m_misp);
      if (enq_valid && !acc) m_drop = sat_inc(m_drop);
      if (kill)             m_kill = sat_inc(m_kill);
    end
    m_last = acc;
    @(negedge clk);
  endtask

  initial begin
    // ev pc misp kill rdy clr | valid chkpc e_pc empty full acc misp drop kill
    tbl.push_back('{1, 31'h800, 1, 0, 0, 0,  0, 0, 31'h0,   1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h800, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 31'h10,  0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 31'h20,  0, 0, 0, 0,  1, 1, 31'h10,  0, 0, 2, 1, 0, 0});
    tbl.push_back('{1, 31'h30,  0, 0, 0, 0,  1, 1, 31'h10,  0, 0, 3, 1, 0, 0});
    tbl.push_back('{1, 31'h40,  0, 0, 0, 0,  1, 1, 31'h10,  0, 0, 4, 1, 0, 0});
    tbl.push_back('{1, 31'h50,  0, 0, 0, 0,  1, 1, 31'h10,  0, 1, 5, 1, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h10,  0, 1, 5, 1, 1, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h20,  0, 0, 5, 1, 1, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h30,  0, 0, 5, 1, 1, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h40,  0, 0, 5, 1, 1, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 5, 1, 1, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 0, 1,  0, 0, 31'h0,   1, 0, 5, 1, 1, 0});
    tbl.push_back('{1, 31'h100, 0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 31'h104, 0, 0, 0, 0,  1, 1, 31'h100, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 31'h108, 0, 0, 0, 0,  1, 1, 31'h100, 0, 0, 2, 0, 0, 0});
    tbl.push_back('{1, 31'h10C, 0, 0, 0, 0,  1, 1, 31'h100, 0, 0, 3, 0, 0, 0});
    tbl.push_back('{1, 31'h110, 0, 0, 1, 0,  1, 1, 31'h100, 0, 1, 4, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 0, 0,  1, 1, 31'h104, 0, 1, 5, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h104, 0, 1, 5, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h108, 0, 0, 5, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h10C, 0, 0, 5, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  1, 1, 31'h110, 0, 0, 5, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 5, 0, 0, 0});
    tbl.push_back('{1, 31'h55,  0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 5, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 1, 1, 0,  0, 1, 31'h55,  0, 0, 6, 0, 0, 0});
    tbl.push_back('{0, 31'h0,   0, 0, 1, 0,  0, 0, 31'h0,   1, 0, 6, 0, 0, 1});
    tbl.push_back('{1, 31'hA0,  0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 6, 0, 0, 1});
    tbl.push_back('{1, 31'hB0,  0, 1, 0, 0,  0, 1, 31'hA0,  0, 0, 7, 0, 0, 1});
    tbl.push_back('{0, 31'h0,   0, 1, 0, 0,  0, 1, 31'hB0,  0, 0, 8, 0, 0, 2});
    tbl.push_back('{0, 31'h0,   0, 1, 0, 0,  0, 0, 31'h0,   1, 0, 8, 0, 0, 3});
    tbl.push_back('{0, 31'h0,   0, 0, 0, 0,  0, 0, 31'h0,   1, 0, 8, 0, 0, 3});

    do_reset();
    #1;
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_payload", {upd_pc, upd_misp, upd_ataken, upd_hist, upd_way}, 0);
    chk("rst_counters", {cnt_accept, cnt_misp, cnt_drop, cnt_kill}, 0);
    @(negedge clk);

    foreach (tbl[i]) begin
      enq_valid = tbl[i].ev;   enq_pc = tbl[i].pc; enq_misp = tbl[i].misp;
      enq_kill  = tbl[i].kill; upd_ready = tbl[i].rdy; stat_clr = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_upd_valid", i), upd_valid, tbl[i].e_valid);
      if (tbl[i].chk_pc) chk($sformatf("v%0d_upd_pc", i), upd_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
      chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("v%0d_cnt_accept", i), cnt_accept, tbl[i].e_acc);
      chk($sformatf("v%0d_cnt_misp", i), cnt_misp, tbl[i].e_misp);
      chk($sformatf("v%0d_cnt_drop", i), cnt_drop, tbl[i].e_drop);
      chk($sformatf("v%0d_cnt_kill", i), cnt_kill, tbl[i].e_kill);
      @(negedge clk);
    end

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      enq_valid  = ($urandom_range(99) < 60);
      enq_pc     = 31'($urandom);
      enq_misp   = 1'($urandom);
      enq_ataken = 1'($urandom);
      enq_hist   = 2'($urandom);
      enq_way    = 1'($urandom);
      enq_kill   = ($urandom_range(99) < 20);
      upd_ready  = ($urandom_range(99) < 50);
      stat_clr   = ($urandom_range(199) == 0);
      model_cycle();
    end

    do_reset();
    enq_valid = 1; enq_pc = 31'h1234;
    repeat (DEPTH + CNT_MAX + 6) @(negedge clk);
    #1;
    chk("sat_cnt_drop", cnt_drop, 16'hFFFF);
    chk("sat_cnt_accept", cnt_accept, DEPTH);
    chk("sat_full", full, 1);
    @(negedge clk);
    #1;
    chk("sat_cnt_drop_hold", cnt_drop, 16'hFFFF);
    stat_clr = 1;
    @(negedge clk);
    stat_clr = 0; enq_valid = 0;
    #1;
    chk("clr_cnt_drop", cnt_drop, 0);
    chk("clr_cnt_accept", cnt_accept, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
